// File: rtl/smg_capture.sv
// Seven-segment display scraper: samples a multiplexed 6-digit active-low display,
// captures each digit once it is stable, and converts a complete frame to binary and BCD.
module smg_capture #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  an,
    input  logic [7:0]  sseg,
    output logic [19:0] number,
    output logic [23:0] bcd,
    output logic        number_valid,
    output logic        code_err,
    output logic        busy
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    logic [5:0]       r_an_m, r_an_s;
    logic [7:0]       r_sseg_m, r_sseg_s;
    logic [13:0]      r_prev;
    logic [CW-1:0]    r_cnt;
    logic [5:0][3:0]  r_dig, r_snap_dig;
    logic [5:0]       r_err, r_snap_err;
    logic [5:0]       r_mask;
    logic [19:0]      r_acc;
    logic [2:0]       r_idx;
    state_t           r_state, w_next;

    logic [13:0]      w_smp;
    logic             w_same, w_an_ok, w_capture, w_start, w_bad;
    logic [2:0]       w_pos;
    logic [3:0]       w_dig;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an_m   <= '0;
            r_an_s   <= '0;
            r_sseg_m <= '0;
            r_sseg_s <= '0;
            r_prev   <= '0;
        end else begin
            r_an_m   <= an;
            r_an_s   <= r_an_m;
            r_sseg_m <= sseg;
            r_sseg_s <= r_sseg_m;
            r_prev   <= w_smp;
        end
    end

    assign w_smp  = {r_an_s, r_sseg_s};
    assign w_same = (w_smp == r_prev);

    // Only a single low enable addresses a digit; blanking and overlap are ignored.
    always_comb begin
        w_an_ok = 1'b1;
        w_pos   = 3'd0;
        case (r_an_s)
            6'b111110: w_pos = 3'd0;
            6'b111101: w_pos = 3'd1;
            6'b111011: w_pos = 3'd2;
            6'b110111: w_pos = 3'd3;
            6'b101111: w_pos = 3'd4;
            6'b011111: w_pos = 3'd5;
            default:   w_an_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_bad = 1'b0;
        w_dig = 4'd0;
        case (r_sseg_s[6:0])
            7'h40:   w_dig = 4'd0;
            7'h79:   w_dig = 4'd1;
            7'h24:   w_dig = 4'd2;
            7'h30:   w_dig = 4'd3;
            7'h19:   w_dig = 4'd4;
            7'h12:   w_dig = 4'd5;
            7'h02:   w_dig = 4'd6;
            7'h78:   w_dig = 4'd7;
            7'h00:   w_dig = 4'd8;
            7'h10:   w_dig = 4'd9;
            default: w_bad = 1'b1;
        endcase
    end

    // Counter saturates at CNT_LAST so a held digit is captured only once.
    assign w_capture = w_an_ok && w_same && (r_cnt == CNT_PRE);

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (!w_an_ok || !w_same)
            r_cnt <= '0;
        else if (r_cnt != CNT_LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    assign w_start = (r_state == S_IDLE) && (r_mask == 6'b111111);

    // Capture is written after the start clear so a same-edge capture keeps its bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dig  <= '0;
            r_err  <= '0;
            r_mask <= '0;
        end else begin
            if (w_start)
                r_mask <= '0;
            if (w_capture) begin
                r_dig[w_pos]  <= w_dig;
                r_err[w_pos]  <= w_bad;
                r_mask[w_pos] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_CONV;
            S_CONV:  if (r_idx == 3'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap_dig   <= '0;
            r_snap_err   <= '0;
            r_acc        <= '0;
            r_idx        <= '0;
            number       <= '0;
            bcd          <= '0;
            code_err     <= 1'b0;
            number_valid <= 1'b0;
        end else begin
            number_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_snap_dig <= r_dig;
                        r_snap_err <= r_err;
                        r_acc      <= '0;
                        r_idx      <= 3'd5;
                    end
                end
                S_CONV: begin
                    // Most significant digit first: acc*10 as shift-and-add.
                    r_acc <= (r_acc << 3) + (r_acc << 1) + 20'(r_snap_dig[r_idx]);
                    r_idx <= r_idx - 1'b1;
                end
                S_DONE: begin
                    number       <= r_acc;
                    bcd          <= r_snap_dig;
                    code_err     <= |r_snap_err;
                    number_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/smg_capture.md
SMG_CAPTURE -- requirements
Module: smg_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive identical samples needed to capture a digit; legal range 2..1023.
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port an  input  6  digit enables, active-low; an[0] is the units digit, an[5] is the hundred-thousands digit.
REQ-005 SHALL have port sseg  input  8  segment lines, active-low; sseg[7] is the decimal point; sseg[6:0] is g..a.
REQ-006 SHALL have port number  output  20  binary value of the last completed frame.
REQ-007 SHALL have port bcd  output  24  BCD digits of the last completed frame; [23:20] is the hundred-thousands digit.
REQ-008 SHALL have port number_valid  output  1  one-cycle pulse when number, bcd and code_err update.
REQ-009 SHALL have port code_err  output  1  last completed frame contained an undecodable segment code.
REQ-010 SHALL have port busy  output  1  high while the FSM is not in IDLE.

Function
REQ-011 SHALL pass an and sseg through a two-flop synchronizer; all further logic uses the synchronized copies.
REQ-012 SHALL treat an as valid only when it is 111110, 111101, 111011, 110111, 101111 or 011111; any other pattern, including all-high and multiple-low, is ignored and clears the stability counter.
REQ-013 SHALL increment the stability counter while the synchronized {an,sseg} is valid and equal to the previous sample; any change clears it to 0.
REQ-014 SHALL capture exactly once, on the sample where the count reaches STABLE_CYCLES-1; the counter then saturates, with no recapture until {an,sseg} changes.
REQ-015 SHALL decode sseg[6:0] and ignore sseg[7]:
- 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9.
- Any other code stores digit 0 and sets that position's error flag.
REQ-016 SHALL, on capture, write the digit and error flag into the addressed position register and set that position's bit in a 6-bit frame mask; recapturing a position overwrites it.
REQ-017 SHALL define frame-complete as mask==6'b111111 while the FSM is in IDLE; a full mask outside IDLE is held until IDLE.
REQ-018 SHALL have FSM states IDLE, CONV and DONE:
- IDLE->CONV on frame-complete.
- CONV->DONE after 6 cycles.
- DONE->IDLE after 1 cycle.
REQ-019 SHALL, on the IDLE->CONV edge, snapshot the 6 digit and error registers and clear the mask; a capture on the same edge sets its mask bit, so set wins over clear.
REQ-020 SHALL compute in CONV acc = acc*10 + digit[i] for i = 5 down to 0, one digit per cycle:
- acc starts at 0.
- acc*10 is formed as (acc<<3)+(acc<<1).
- acc is 20 bits wide; the maximum result 999999 fits without overflow.
REQ-021 SHALL, in DONE, load number=acc, bcd=snapshot and code_err=OR of the snapshot error flags, and assert number_valid for exactly that cycle.
REQ-022 SHALL make number_valid occur 8 cycles after the cycle in which the mask becomes full, when the FSM is in IDLE at that point.
REQ-023 SHALL hold number, bcd and code_err stable between number_valid pulses.
REQ-024 SHALL continue capturing during CONV and DONE; the snapshot isolates the conversion from these new captures.

Reset
REQ-025 SHALL, when rst_n is sampled low, clear the following to 0 on that edge:
- number, bcd, number_valid, code_err and busy.
- The mask, digit registers, error registers, snapshot, acc, stability counter and synchronizers.
- FSM returns to IDLE.
REQ-026 SHALL abort any conversion in progress on reset, with no number_valid pulse and no partial result on the outputs.

Verification
REQ-027 SHALL cover: frame for digits 1,2,3,4,5,6 (sseg F9,A4,B0,99,92,82 on an[5]..an[0]), each held 16 cycles -> exactly one number_valid pulse; number=20'h1E240 (123456), bcd=24'h123456, code_err=0.
REQ-028 SHALL cover: an=111110 with sseg=C0 held 10 cycles, then an=111111 -> no capture; mask bit 0 stays 0; no number_valid.
REQ-029 SHALL cover: frame for 999999 with sseg=FF at an[2] -> number=999099, bcd=24'h999099, code_err=1.
REQ-030 SHALL cover: an=000000 and an=111111 each held 100 cycles -> no capture; busy=0.
REQ-031 SHALL cover: sseg=40 (decimal point lit) at every position -> decodes as 0; number=0, code_err=0, and number_valid pulses once.
REQ-032 SHALL cover: rst_n low for 1 cycle at the 3rd CONV cycle -> no number_valid; all outputs 0; the next full frame converts correctly.
